// File: rtl/present_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : present_round_engine
// Purpose  : Iterative PRESENT-style SPN cipher core, one round per clock,
//            encrypt/decrypt with 80- or 128-bit keys.
// Revision : 1.0 - initial release
// ============================================================================
module present_round_engine #(
    parameter int KEY_BITS = 80,
    parameter int ROUNDS   = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_decrypt,
    input  logic [KEY_BITS-1:0] in_key,
    input  logic [63:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_data
);

    generate
        if (!(KEY_BITS == 80 || KEY_BITS == 128)) begin : g_bad_key_bits
            $error("present_round_engine: KEY_BITS must be 80 or 128");
        end
        if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
            $error("present_round_engine: ROUNDS must be in 1..31");
        end
    endgenerate

    localparam int         CTR_LSB    = (KEY_BITS == 80) ? 15 : 62;
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    typedef enum logic [1:0] {IDLE, KEYFWD, RUN, DONE} state_t;

    state_t              r_fsm;
    logic [63:0]         r_state;
    logic [KEY_BITS-1:0] r_key;
    logic [4:0]          r_ctr;
    logic                r_decrypt;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h2174_8FE3_DA09_B65C;
        return tbl[4*x +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hA970_364B_D21C_8FE5;
        return tbl[4*x +: 4];
    endfunction

    function automatic logic [63:0] enc_layers(input logic [63:0] x);
        logic [63:0] s;
        logic [63:0] y;
        for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(x[4*n +: 4]);
        y = '0;
        for (int j = 0; j < 63; j++) y[(16*j) % 63] = s[j];
        y[63] = s[63];
        return y;
    endfunction

    function automatic logic [63:0] dec_layers(input logic [63:0] x);
        logic [63:0] p;
        logic [63:0] y;
        for (int j = 0; j < 63; j++) p[j] = x[(16*j) % 63];
        p[63] = x[63];
        for (int n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox(p[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [KEY_BITS-1:0] key_fwd(input logic [KEY_BITS-1:0] k,
                                                    input logic [4:0] ctr);
        logic [KEY_BITS-1:0] t;
        t = {k[KEY_BITS-62:0], k[KEY_BITS-1:KEY_BITS-61]};
        t[KEY_BITS-1 -: 4] = sbox(t[KEY_BITS-1 -: 4]);
        if (KEY_BITS == 128) t[KEY_BITS-5 -: 4] = sbox(t[KEY_BITS-5 -: 4]);
        t[CTR_LSB +: 5] = t[CTR_LSB +: 5] ^ ctr;
        return t;
    endfunction

    function automatic logic [KEY_BITS-1:0] key_inv(input logic [KEY_BITS-1:0] k,
                                                    input logic [4:0] ctr);
        logic [KEY_BITS-1:0] t;
        t = k;
        t[CTR_LSB +: 5] = t[CTR_LSB +: 5] ^ ctr;
        t[KEY_BITS-1 -: 4] = inv_sbox(t[KEY_BITS-1 -: 4]);
        if (KEY_BITS == 128) t[KEY_BITS-5 -: 4] = inv_sbox(t[KEY_BITS-5 -: 4]);
        return {t[60:0], t[KEY_BITS-1:61]};
    endfunction

    logic [63:0]         w_mixed;
    logic [63:0]         w_next_state;
    logic [KEY_BITS-1:0] w_fwd_key;
    logic [KEY_BITS-1:0] w_next_key;
    logic                w_last;

    always_comb begin
        w_mixed      = r_state ^ r_key[KEY_BITS-1 -: 64];
        w_fwd_key    = key_fwd(r_key, r_ctr);
        w_next_state = r_decrypt ? dec_layers(w_mixed) : enc_layers(w_mixed);
        w_next_key   = r_decrypt ? key_inv(r_key, r_ctr) : w_fwd_key;
        w_last       = r_decrypt ? (r_ctr == 5'd1) : (r_ctr == LAST_ROUND);
    end

    assign in_ready = (r_fsm == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= IDLE;
            r_state   <= '0;
            r_key     <= '0;
            r_ctr     <= '0;
            r_decrypt <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state   <= in_data;
                        r_key     <= in_key;
                        r_ctr     <= 5'd1;
                        r_decrypt <= in_decrypt;
                        r_fsm     <= in_decrypt ? KEYFWD : RUN;
                    end
                end
                // Decryption starts from the last round key, so walk the schedule forward first.
                KEYFWD: begin
                    r_key <= w_fwd_key;
                    if (r_ctr == LAST_ROUND) begin
                        r_fsm <= RUN;
                    end else begin
                        r_ctr <= r_ctr + 5'd1;
                    end
                end
                RUN: begin
                    r_state <= w_next_state;
                    r_key   <= w_next_key;
                    if (w_last) begin
                        out_data  <= w_next_state ^ w_next_key[KEY_BITS-1 -: 64];
                        out_valid <= 1'b1;
                        r_fsm     <= DONE;
                    end else begin
                        r_ctr <= r_decrypt ? (r_ctr - 5'd1) : (r_ctr + 5'd1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_fsm     <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
